// File: rtl/iq_byte_packer.sv
// I/Q pair reducer (24->16 bits per channel), 16-pair FIFO and 4-byte serialiser with valid/ready.
// Define IQ_PACKER_ROUND_EN for round-half-up with saturation; the default build truncates.
module iq_byte_packer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int IN_W       = 24,
  parameter int OUT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_strobe,
  input  logic [IN_W-1:0]       in_i,
  input  logic [IN_W-1:0]       in_q,
  output logic [7:0]            out_data,
  output logic                  out_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic [7:0]            overflow_cnt,
  input  logic                  clr_ovf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);

`ifdef IQ_PACKER_ROUND_EN
  localparam logic [IN_W:0] RND_HALF = (IN_W+1)'(1) << (IN_W-OUT_W-1);

  // Only positive inputs can carry into the sign position, so 2'b01 on the top bits means overflow.
  function automatic logic [OUT_W-1:0] reduce(input logic [IN_W-1:0] s);
    logic [IN_W:0] r;
    r = {s[IN_W-1], s} + RND_HALF;
    if (r[IN_W:IN_W-1] == 2'b01)
      reduce = {1'b0, {(OUT_W-1){1'b1}}};
    else
      reduce = r[IN_W-1:IN_W-OUT_W];
  endfunction
`else
  function automatic logic [OUT_W-1:0] reduce(input logic [IN_W-1:0] s);
    reduce = s[IN_W-1:IN_W-OUT_W];
  endfunction
`endif

  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} state_t;

  state_t                  state_reg, state_next;
  logic [2*OUT_W-1:0]      mem [DEPTH];
  logic [2*OUT_W-1:0]      word_reg;
  logic [DEPTH_LOG2-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]     level_reg;
  logic [7:0]              ovf_reg;
  logic                    pop, push, handshake, fifo_empty, fifo_full;
  logic [2*OUT_W-1:0]      word_in;

  assign word_in    = {reduce(in_q), reduce(in_i)};
  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LEVEL_FULL);
  assign handshake  = out_valid && out_ready;
  // A full FIFO still accepts when the serialiser frees a slot on the same edge.
  assign push       = in_strobe && (!fifo_full || pop);

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: if (!fifo_empty) begin
        pop        = 1'b1;
        state_next = B0;
      end
      B0: if (handshake) state_next = B1;
      B1: if (handshake) state_next = B2;
      B2: if (handshake) state_next = B3;
      B3: if (handshake) begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = B0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_reg != IDLE);
    out_first = (state_reg == B0);
    case (state_reg)
      B0:      out_data = word_reg[7:0];
      B1:      out_data = word_reg[15:8];
      B2:      out_data = word_reg[23:16];
      B3:      out_data = word_reg[31:24];
      default: out_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr_reg] <= word_in;

  // Registered read; on a full-FIFO push+pop the read returns the old (oldest) word.
  always_ff @(posedge clk)
    if (pop) word_reg <= mem[rd_ptr_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + (DEPTH_LOG2+1)'(1);
        2'b01:   level_reg <= level_reg - (DEPTH_LOG2+1)'(1);
        default: level_reg <= level_reg;
      endcase
      if (clr_ovf)
        ovf_reg <= 8'h00;
      else if (in_strobe && !push && ovf_reg != 8'hFF)
        ovf_reg <= ovf_reg + 8'h01;
    end
  end

  assign level        = level_reg;
  assign overflow_cnt = ovf_reg;

endmodule

// File: tb/tb_iq_byte_packer.sv
// Randomised bench for iq_byte_packer against a queue-based pair/byte reference model.
module tb_iq_byte_packer;

  logic        clk = 1'b0;
  logic        reset, in_strobe, out_ready, clr_ovf;
  logic [23:0] in_i, in_q;
  logic [7:0]  out_data, overflow_cnt;
  logic        out_first, out_valid;
  logic [4:0]  level;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_fifo[$];
  logic [31:0] m_word;
  int          m_idx;
  bit          m_active;
  int          m_ovf;
  logic [7:0]  seen[$];

  iq_byte_packer dut (
    .clk(clk), .reset(reset), .in_strobe(in_strobe), .in_i(in_i), .in_q(in_q),
    .out_data(out_data), .out_first(out_first), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .overflow_cnt(overflow_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_reduce(input logic [23:0] s);
    int v;
    v = int'($signed(s));
`ifdef IQ_PACKER_ROUND_EN
    v = (v + 128) >>> 8;
    if (v > 32767) v = 32767;
`else
    v = v >>> 8;
`endif
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_active = 1'b0;
    m_idx    = 0;
    m_ovf    = 0;
    m_word   = '0;
  endtask

  task automatic check_outputs();
    logic [7:0] eb;
    eb = m_active ? m_word[8*m_idx +: 8] : 8'h00;
    check_eq("out_valid", 32'(out_valid), 32'(m_active));
    check_eq("out_data", 32'(out_data), 32'(eb));
    check_eq("out_first", 32'(out_first), 32'(m_active && m_idx == 0));
    check_eq("level", 32'(level), 32'(m_fifo.size()));
    check_eq("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
  endtask

  // Called at a falling edge: check, drive, advance the model across the next rising edge.
  task automatic step(input bit s, input logic [23:0] i, input logic [23:0] q,
                      input bit rdy, input bit clr);
    bit hs, pop, accept;
    check_outputs();
    in_strobe = s; in_i = i; in_q = q; out_ready = rdy; clr_ovf = clr;
    if (out_valid && rdy) seen.push_back(out_data);
    hs  = m_active && rdy;
    pop = (!m_active || (hs && m_idx == 3)) && (m_fifo.size() > 0);
    accept = s && (m_fifo.size() < 16 || pop);
    if (pop) begin
      m_word   = m_fifo.pop_front();
      m_active = 1'b1;
      m_idx    = 0;
    end else if (hs) begin
      if (m_idx == 3) m_active = 1'b0;
      else m_idx++;
    end
    if (accept) m_fifo.push_back({ref_reduce(q), ref_reduce(i)});
    if (clr) m_ovf = 0;
    else if (s && !accept && m_ovf < 255) m_ovf++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, 24'h0, 24'h0, rdy, 1'b0);
  endtask

  logic [23:0] rt_in  [3] = '{24'h123480, 24'h7FFFC0, 24'hFFFF80};
`ifdef IQ_PACKER_ROUND_EN
  logic [15:0] rt_exp [3] = '{16'h1235, 16'h7FFF, 16'h0000};
`else
  logic [15:0] rt_exp [3] = '{16'h1234, 16'h7FFF, 16'hFFFF};
`endif

  initial begin
    reset = 1'b1; in_strobe = 1'b0; in_i = '0; in_q = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Single pair, truncation/rounding-independent byte order
    seen.delete();
    step(1'b1, 24'h123456, 24'hABCDEF, 1'b1, 1'b0);
    idle(7, 1'b1);
    check_eq("pair_bytes", 32'(seen.size()), 32'd4);
    check_eq("pair_word", {seen[3], seen[2], seen[1], seen[0]},
             {ref_reduce(24'hABCDEF), ref_reduce(24'h123456)});
`ifndef IQ_PACKER_ROUND_EN
    check_eq("pair_const", {seen[3], seen[2], seen[1], seen[0]}, 32'hABCD1234);
`endif

    for (int k = 0; k < 3; k++) begin
      seen.delete();
      step(1'b1, rt_in[k], 24'h0, 1'b1, 1'b0);
      idle(7, 1'b1);
      check_eq("reduce_i", {16'h0, seen[1], seen[0]}, {16'h0, rt_exp[k]});
    end

    // Fill with stalled consumer: 20 strobes, 16 stored + 1 in serialiser, 3 dropped
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 24'($urandom), 24'($urandom), 1'b0, 1'b0);
      idle(3, 1'b0);
    end
    check_eq("fill_level", 32'(level), 32'd16);
    check_eq("fill_ovf", 32'(overflow_cnt), 32'd3);
    seen.delete();
    idle(68, 1'b1);
    check_eq("drain_no_bubble", 32'(seen.size()), 32'd68);
    idle(2, 1'b1);
    step(1'b0, 24'h0, 24'h0, 1'b1, 1'b1);
    check_eq("clr_ovf", 32'(overflow_cnt), 32'd0);

    // Full FIFO, strobe coinciding with the B3 handshake pop
    for (int k = 0; k < 17; k++) step(1'b1, 24'($urandom), 24'($urandom), 1'b0, 1'b0);
    check_eq("full_level", 32'(level), 32'd16);
    step(1'b1, 24'($urandom), 24'($urandom), 1'b0, 1'b0);
    check_eq("full_drop", 32'(overflow_cnt), 32'd1);
    idle(3, 1'b1);
    step(1'b1, 24'($urandom), 24'($urandom), 1'b1, 1'b0);
    check_eq("full_pop_level", 32'(level), 32'd16);
    check_eq("full_pop_ovf", 32'(overflow_cnt), 32'd1);
    idle(80, 1'b1);

    // Ready toggling mid-pair
    step(1'b1, 24'($urandom), 24'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 24'h0, 24'h0, (k % 2) == 0, 1'b0);

    // Random traffic
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 3) == 0, 24'($urandom), 24'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
    idle(80, 1'b1);

    // Asynchronous reset while the serialiser sits in B2 with five pairs queued
    for (int k = 0; k < 6; k++) step(1'b1, 24'($urandom), 24'($urandom), 1'b0, 1'b0);
    idle(2, 1'b1);
    check_outputs();
    check_eq("pre_reset_level", 32'(level), 32'd5);
    reset = 1'b1;
    #1;
    check_eq("async_valid", 32'(out_valid), 32'd0);
    check_eq("async_level", 32'(level), 32'd0);
    check_eq("async_first", 32'(out_first), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 24'h0A0B0C, 24'h0D0E0F, 1'b1, 1'b0);
    idle(8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
